// File: rtl/lsu_mem_resp.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_mem_resp
//  Description : Load/store unit memory handshake. Issues one word access per
//                decode request on a req/gnt/rvalid bus, stalls the pipeline
//                while the access is outstanding and reports misalignment,
//                load+store conflict and bus timeout as a one-cycle error.
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_mem_resp #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        loadReq,
  input  logic        storeReq,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        err,
  output logic [1:0]  errCode,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0]  c_ERR_NONE = 2'b00;
  localparam logic [1:0]  c_ERR_MIS  = 2'b01;
  localparam logic [1:0]  c_ERR_TMO  = 2'b10;
  localparam logic [1:0]  c_ERR_CONF = 2'b11;
  // Counter value seen in the last permitted REQ/WAIT cycle.
  localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_is_load;
  logic [15:0] r_tcnt;
  logic [1:0]  r_ecode;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_rdata;

  logic        w_start;
  logic        w_set_err;
  logic [1:0]  w_err_val;
  logic        w_capture;
  logic        w_clr_rdata;
  logic        w_tmo;

  assign w_tmo = (r_tcnt == c_TMO_LAST);

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and per-cycle datapath decisions.
  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_set_err   = 1'b0;
    w_err_val   = c_ERR_NONE;
    w_capture   = 1'b0;
    w_clr_rdata = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (loadReq && storeReq) begin
          // Conflict outranks misalignment; neither touches the bus.
          w_next    = S_DONE;
          w_set_err = 1'b1;
          w_err_val = c_ERR_CONF;
        end else if (loadReq || storeReq) begin
          if (addr[1:0] != 2'b00) begin
            w_next      = S_DONE;
            w_set_err   = 1'b1;
            w_err_val   = c_ERR_MIS;
            w_clr_rdata = loadReq;
          end else begin
            w_next  = S_REQ;
            w_start = 1'b1;
          end
        end
      end
      S_REQ: begin
        // A grant on the final allowed cycle still loses to the timeout.
        if (w_tmo) begin
          w_next      = S_DONE;
          w_set_err   = 1'b1;
          w_err_val   = c_ERR_TMO;
          w_clr_rdata = r_is_load;
        end else if (mem_gnt) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response on the final allowed cycle completes normally.
        if (mem_rvalid) begin
          w_next    = S_DONE;
          w_capture = r_is_load;
        end else if (w_tmo) begin
          w_next      = S_DONE;
          w_set_err   = 1'b1;
          w_err_val   = c_ERR_TMO;
          w_clr_rdata = r_is_load;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch, timeout counter and error record.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_is_load   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_tcnt      <= 16'd0;
      r_ecode     <= c_ERR_NONE;
    end else begin
      if (w_start) begin
        r_is_load   <= loadReq;
        r_mem_we    <= storeReq;
        r_mem_addr  <= {addr[31:2], 2'b00};
        r_mem_wdata <= wdata;
        r_tcnt      <= 16'd0;
        r_ecode     <= c_ERR_NONE;
      end else if (r_state == S_REQ || r_state == S_WAIT) begin
        r_tcnt <= r_tcnt + 16'd1;
      end
      if (w_set_err) r_ecode <= w_err_val;
      else if (r_state == S_DONE) r_ecode <= c_ERR_NONE;
    end
  end

  // Load result register: updated only by a load capture or a load error.
  always_ff @(posedge clk) begin
    if (!rst_n)           r_rdata <= 32'd0;
    else if (w_capture)   r_rdata <= mem_rdata;
    else if (w_clr_rdata) r_rdata <= 32'd0;
  end

  assign mem_req   = (r_state == S_REQ);
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rdata     = r_rdata;
  assign stall     = rst_n & (((r_state == S_IDLE) & (loadReq | storeReq)) |
                              (r_state == S_REQ) | (r_state == S_WAIT));
  assign err       = (r_state == S_DONE) & (r_ecode != c_ERR_NONE);
  assign errCode   = err ? r_ecode : c_ERR_NONE;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_resp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_mem_resp
//  Description : Directed self-checking bench for lsu_mem_resp. A second
//                instance with a short timeout shares all inputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lsu_mem_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        loadReq, storeReq;
  logic [31:0] addr, wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  logic [31:0] rdata, mem_addr, mem_wdata;
  logic        stall, err, mem_req, mem_we;
  logic [1:0]  errCode;

  logic [31:0] t_rdata, t_mem_addr, t_mem_wdata;
  logic        t_stall, t_err, t_mem_req, t_mem_we;
  logic [1:0]  t_errCode;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  lsu_mem_resp dut (
    .clk(clk), .rst_n(rst_n), .loadReq(loadReq), .storeReq(storeReq),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .err(err),
    .errCode(errCode), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  lsu_mem_resp #(.TIMEOUT_CYC(4)) dut_t (
    .clk(clk), .rst_n(rst_n), .loadReq(loadReq), .storeReq(storeReq),
    .addr(addr), .wdata(wdata), .rdata(t_rdata), .stall(t_stall), .err(t_err),
    .errCode(t_errCode), .mem_req(t_mem_req), .mem_we(t_mem_we),
    .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] d);
    loadReq = 1'b1; addr = a; tick();
    loadReq = 1'b0; mem_gnt = 1'b1; tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = d; tick();
    mem_rvalid = 1'b0; tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; loadReq = 1'b1; addr = 32'h100; #1;
    total_cnt++; if (stall !== 1'b0) $display("FAIL rst_stall_comb actual=%0h required=0", stall); else pass_cnt++;
    tick(); tick();
    total_cnt++; if (stall !== 1'b0) $display("FAIL rst_stall actual=%0h required=0", stall); else pass_cnt++;
    total_cnt++; if (mem_req !== 1'b0 || mem_we !== 1'b0) $display("FAIL rst_req_we actual=%0h%0h required=00", mem_req, mem_we); else pass_cnt++;
    total_cnt++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) $display("FAIL rst_addr_data actual=%0h/%0h required=0/0", mem_addr, mem_wdata); else pass_cnt++;
    total_cnt++; if (rdata !== 32'd0 || err !== 1'b0 || errCode !== 2'b00) $display("FAIL rst_rdata_err actual=%0h/%0h/%0h required=0/0/0", rdata, err, errCode); else pass_cnt++;
    loadReq = 1'b0; rst_n = 1'b1; tick();
  endtask

  task automatic test_load();
    loadReq = 1'b1; addr = 32'h100; #1;
    total_cnt++; if (stall !== 1'b1 || mem_req !== 1'b0) $display("FAIL lw_c0 stall/req actual=%0h/%0h required=1/0", stall, mem_req); else pass_cnt++;
    tick(); loadReq = 1'b0; mem_gnt = 1'b1; #1;
    total_cnt++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100 || stall !== 1'b1) $display("FAIL lw_c1 req/we/addr/stall actual=%0h/%0h/%0h/%0h required=1/0/100/1", mem_req, mem_we, mem_addr, stall); else pass_cnt++;
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
    total_cnt++; if (mem_req !== 1'b0 || stall !== 1'b1) $display("FAIL lw_c2 req/stall actual=%0h/%0h required=0/1", mem_req, stall); else pass_cnt++;
    tick(); mem_rvalid = 1'b0; #1;
    total_cnt++; if (stall !== 1'b0 || err !== 1'b0 || errCode !== 2'b00) $display("FAIL lw_c3 stall/err/code actual=%0h/%0h/%0h required=0/0/0", stall, err, errCode); else pass_cnt++;
    total_cnt++; if (rdata !== 32'hDEADBEEF) $display("FAIL lw_rdata actual=%0h required=deadbeef", rdata); else pass_cnt++;
    tick();
  endtask

  task automatic test_store();
    int held;
    held = 0;
    storeReq = 1'b1; addr = 32'h204; wdata = 32'h12345678; tick();
    storeReq = 1'b0; addr = 32'hFFFF_FFF0; wdata = 32'h0;
    for (int i = 0; i < 6; i++) begin
      mem_gnt = (i == 5); #1;
      if (mem_req === 1'b1) held++;
      total_cnt++; if (mem_we !== 1'b1 || mem_addr !== 32'h204 || mem_wdata !== 32'h12345678) $display("FAIL sw_hold we/addr/data actual=%0h/%0h/%0h required=1/204/12345678", mem_we, mem_addr, mem_wdata); else pass_cnt++;
      tick();
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD0BAD; #1;
    total_cnt++; if (held !== 6 || mem_req !== 1'b0) $display("FAIL sw_req_cycles actual=%0d/%0h required=6/0", held, mem_req); else pass_cnt++;
    tick(); mem_rvalid = 1'b0; #1;
    total_cnt++; if (err !== 1'b0 || stall !== 1'b0 || rdata !== 32'hDEADBEEF) $display("FAIL sw_done err/stall/rdata actual=%0h/%0h/%0h required=0/0/deadbeef", err, stall, rdata); else pass_cnt++;
    tick();
  endtask

  task automatic test_misaligned();
    storeReq = 1'b1; addr = 32'h206; #1;
    total_cnt++; if (stall !== 1'b1 || mem_req !== 1'b0) $display("FAIL mis_sw_c0 stall/req actual=%0h/%0h required=1/0", stall, mem_req); else pass_cnt++;
    tick(); storeReq = 1'b0; #1;
    total_cnt++; if (err !== 1'b1 || errCode !== 2'b01 || rdata !== 32'hDEADBEEF || mem_req !== 1'b0) $display("FAIL mis_sw_done err/code/rdata/req actual=%0h/%0h/%0h/%0h required=1/1/deadbeef/0", err, errCode, rdata, mem_req); else pass_cnt++;
    tick();
    loadReq = 1'b1; addr = 32'h102; tick();
    total_cnt++; if (err !== 1'b1 || errCode !== 2'b01 || rdata !== 32'd0 || mem_req !== 1'b0 || stall !== 1'b0) $display("FAIL mis_lw_done err/code/rdata/req/stall actual=%0h/%0h/%0h/%0h/%0h required=1/1/0/0/0", err, errCode, rdata, mem_req, stall); else pass_cnt++;
    loadReq = 1'b0; tick();
    total_cnt++; if (err !== 1'b0 || errCode !== 2'b00 || mem_req !== 1'b0 || stall !== 1'b0) $display("FAIL mis_after err/code/req/stall actual=%0h/%0h/%0h/%0h required=0/0/0/0", err, errCode, mem_req, stall); else pass_cnt++;
  endtask

  task automatic test_conflict();
    loadReq = 1'b1; storeReq = 1'b1; addr = 32'h102; #1;
    total_cnt++; if (stall !== 1'b1 || mem_req !== 1'b0) $display("FAIL conf_c0 stall/req actual=%0h/%0h required=1/0", stall, mem_req); else pass_cnt++;
    tick(); loadReq = 1'b0; storeReq = 1'b0; #1;
    total_cnt++; if (err !== 1'b1 || errCode !== 2'b11 || mem_req !== 1'b0) $display("FAIL conf_done err/code/req actual=%0h/%0h/%0h required=1/3/0", err, errCode, mem_req); else pass_cnt++;
    tick();
    total_cnt++; if (err !== 1'b0 || errCode !== 2'b00) $display("FAIL conf_after err/code actual=%0h/%0h required=0/0", err, errCode); else pass_cnt++;
  endtask

  task automatic test_timeout();
    do_load(32'h300, 32'h0BADF00D);
    total_cnt++; if (t_rdata !== 32'h0BADF00D) $display("FAIL tmo_preload actual=%0h required=badf00d", t_rdata); else pass_cnt++;
    loadReq = 1'b1; addr = 32'h40; tick(); loadReq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total_cnt++; if (t_mem_req !== 1'b1 || t_stall !== 1'b1) $display("FAIL tmo_req_cycle%0d req/stall actual=%0h/%0h required=1/1", i, t_mem_req, t_stall); else pass_cnt++;
      tick();
    end
    total_cnt++; if (t_mem_req !== 1'b0 || t_err !== 1'b1 || t_errCode !== 2'b10 || t_rdata !== 32'd0) $display("FAIL tmo_done req/err/code/rdata actual=%0h/%0h/%0h/%0h required=0/1/2/0", t_mem_req, t_err, t_errCode, t_rdata); else pass_cnt++;
    mem_rvalid = 1'b1; mem_rdata = 32'h55; tick(); mem_rvalid = 1'b0;
    total_cnt++; if (t_err !== 1'b0 || t_errCode !== 2'b00 || t_stall !== 1'b0) $display("FAIL tmo_idle err/code/stall actual=%0h/%0h/%0h required=0/0/0", t_err, t_errCode, t_stall); else pass_cnt++;
    tick();
    total_cnt++; if (t_rdata !== 32'd0 || t_err !== 1'b0) $display("FAIL tmo_late_rvalid rdata/err actual=%0h/%0h required=0/0", t_rdata, t_err); else pass_cnt++;
    apply_reset(); tick();
  endtask

  task automatic test_reset_mid_access();
    do_load(32'h80, 32'h11223344);
    total_cnt++; if (rdata !== 32'h11223344) $display("FAIL rstmid_preload actual=%0h required=11223344", rdata); else pass_cnt++;
    loadReq = 1'b1; addr = 32'h100; tick();
    loadReq = 1'b0; mem_gnt = 1'b1; tick(); mem_gnt = 1'b0; #1;
    total_cnt++; if (stall !== 1'b1 || mem_req !== 1'b0) $display("FAIL rstmid_wait stall/req actual=%0h/%0h required=1/0", stall, mem_req); else pass_cnt++;
    rst_n = 1'b0; #1;
    total_cnt++; if (stall !== 1'b0) $display("FAIL rstmid_stall_comb actual=%0h required=0", stall); else pass_cnt++;
    tick();
    total_cnt++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) $display("FAIL rstmid_bus req/we/addr/data actual=%0h/%0h/%0h/%0h required=0/0/0/0", mem_req, mem_we, mem_addr, mem_wdata); else pass_cnt++;
    total_cnt++; if (rdata !== 32'd0 || err !== 1'b0 || errCode !== 2'b00 || stall !== 1'b0) $display("FAIL rstmid_out rdata/err/code/stall actual=%0h/%0h/%0h/%0h required=0/0/0/0", rdata, err, errCode, stall); else pass_cnt++;
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D; tick(); mem_rvalid = 1'b0; #1;
    total_cnt++; if (rdata !== 32'd0 || err !== 1'b0 || stall !== 1'b0 || mem_req !== 1'b0) $display("FAIL rstmid_late rdata/err/stall/req actual=%0h/%0h/%0h/%0h required=0/0/0/0", rdata, err, stall, mem_req); else pass_cnt++;
    tick();
    total_cnt++; if (err !== 1'b0 || rdata !== 32'd0) $display("FAIL rstmid_after err/rdata actual=%0h/%0h required=0/0", err, rdata); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_load(32'h10, 32'hA5A5A5A5);
    loadReq = 1'b1; addr = 32'h14; #1;
    total_cnt++; if (stall !== 1'b1 || rdata !== 32'hA5A5A5A5) $display("FAIL b2b_start stall/rdata actual=%0h/%0h required=1/a5a5a5a5", stall, rdata); else pass_cnt++;
    tick(); loadReq = 1'b0; mem_gnt = 1'b1; #1;
    total_cnt++; if (mem_req !== 1'b1 || mem_addr !== 32'h14) $display("FAIL b2b_req req/addr actual=%0h/%0h required=1/14", mem_req, mem_addr); else pass_cnt++;
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5A5A5A5A; tick(); mem_rvalid = 1'b0; #1;
    total_cnt++; if (rdata !== 32'h5A5A5A5A || err !== 1'b0) $display("FAIL b2b_done rdata/err actual=%0h/%0h required=5a5a5a5a/0", rdata, err); else pass_cnt++;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; loadReq = 1'b0; storeReq = 1'b0; addr = 32'd0; wdata = 32'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    tick();
    test_reset();
    test_load();
    test_store();
    test_misaligned();
    test_conflict();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/lsu_mem_resp.md
LSU_MEM_RESP -- requirements
Module: lsu_mem_resp

Interface
REQ-001 Parameter: TIMEOUT_CYC, 255, number of cycles spent in REQ+WAIT before the access is aborted (range 2..65535).
REQ-002 Clock and reset: one clock, clk; reset rst_n is synchronous and active-low.
REQ-003 Port: clk  in  1  system clock; all state updates on its rising edge.
REQ-004 Port: rst_n  in  1  synchronous active-low reset.
REQ-005 Port: loadReq  in  1  word load requested by decode (LW).
REQ-006 Port: storeReq  in  1  word store requested by decode (SW).
REQ-007 Port: addr  in  32  byte address from ALU result.
REQ-008 Port: wdata  in  32  store data (rs2).
REQ-009 Port: rdata  out  32  load result to writeback mux (mem2reg=01 path).
REQ-010 Port: stall  out  1  freeze pipeline while access is outstanding.
REQ-011 Port: err  out  1  one-cycle access-error pulse.
REQ-012 Port: errCode  out  2  01 misaligned, 10 timeout, 11 load+store conflict, 00 none.
REQ-013 Port: mem_req  out  1  bus request, held until granted.
REQ-014 Port: mem_we  out  1  1 = write, 0 = read; valid with mem_req.
REQ-015 Port: mem_addr  out  32  word address, bits[1:0] always 0.
REQ-016 Port: mem_wdata  out  32  write data; valid with mem_req.
REQ-017 Port: mem_gnt  in  1  memory accepted the request this cycle.
REQ-018 Port: mem_rvalid  in  1  response: read data valid, or write acknowledge.
REQ-019 Port: mem_rdata  in  32  read data; sampled only with mem_rvalid.

Function
REQ-020 The FSM SHALL have the states IDLE, REQ, WAIT and DONE, all registered.
REQ-021 IDLE, one legal request (loadReq xor storeReq), addr[1:0]==0: SHALL latch addr, wdata and op type; next state REQ.
REQ-022 IDLE, misaligned or loadReq&storeReq: SHALL make no bus access; next state DONE with errCode 01 or 11 (the conflict code takes priority).
REQ-023 REQ: mem_req=1 with latched mem_we/mem_addr/mem_wdata, stable until mem_gnt; on mem_gnt next state WAIT, mem_req=0 in the following cycle.
REQ-024 WAIT: on mem_rvalid SHALL capture mem_rdata into rdata (loads only) and go to DONE; mem_rvalid in REQ, IDLE or DONE SHALL be ignored.
REQ-025 Timeout counter: cleared on IDLE->REQ; increments in every REQ/WAIT cycle; on reaching TIMEOUT_CYC SHALL go to DONE with errCode 10 and drop mem_req.
REQ-026 DONE: lasts exactly one cycle, then IDLE; stall=0; err=1 if an error was recorded; loadReq/storeReq ignored in DONE.
REQ-027 stall SHALL equal (IDLE & (loadReq|storeReq)) | REQ | WAIT, and SHALL be 0 while rst_n=0.
REQ-028 rdata SHALL hold its last value except on a load capture (REQ-024) or on a load error, which sets rdata=0.
REQ-029 Stores SHALL leave rdata unchanged.
REQ-030 errCode SHALL be 00 whenever err=0.
REQ-031 Minimum latency: request cycle, REQ with gnt, WAIT with rvalid, DONE, giving 4 cycles, with stall high for the first 3.

Reset
REQ-032 While rst_n=0 at a clock edge: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, err=0, errCode=00, timeout counter=0.
REQ-033 Reset mid-access (REQ/WAIT) SHALL abandon the transaction with no err pulse; a late mem_rvalid after reset SHALL be ignored.

Verification
REQ-034 LW addr=0x100, gnt at cycle 1, rvalid at cycle 2 with rdata 0xDEADBEEF -> stall high cycles 0-2, DONE at cycle 3, rdata=0xDEADBEEF, err=0.
REQ-035 SW addr=0x204, wdata=0x12345678, gnt delayed 5 cycles -> mem_req held for 6 cycles with mem_we=1, addr/data stable; ack then DONE; rdata unchanged.
REQ-036 LW addr=0x102 -> no mem_req, DONE next cycle, err=1, errCode=01, rdata=0.
REQ-037 TIMEOUT_CYC=4, LW with no gnt -> mem_req dropped after 4 REQ cycles, err=1, errCode=10; later rvalid ignored.
REQ-038 loadReq=storeReq=1 -> err=1, errCode=11, no bus activity.
REQ-039 rst_n low during WAIT, then rvalid -> IDLE, all outputs at reset values, no err pulse, rdata=0.
